// File: rtl/idelay_reset_sequencer_pkg.sv
// Shared state encoding and default timing for the IDELAYCTRL sequencer.
// Also consumed by the EPB status register block.
package idelay_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ASSERT_RST = 3'd0,
    WAIT_RDY   = 3'd1,
    SETTLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } seq_state_t;

  localparam int DEF_RST_CYCLES    = 20;
  localparam int DEF_RDY_TIMEOUT   = 4095;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int DEF_RELEASE_DELAY = 16;

  // Width of a counter that must hold 0..n inclusive
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/idelay_reset_sequencer_bit_synchroniser.sv
// Multi-flop synchroniser for a single asynchronous level.
// Resets to 0 so a stale ready can never leak through reset.
module bit_synchroniser #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the async level through the flop chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/idelay_reset_sequencer.sv
// IDELAYCTRL reset/ready sequencer with timeout, bounded retries,
// settle filter before app reset release, and loss-of-ready monitor.
module idelay_reset_sequencer
  import idelay_reset_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int RDY_TIMEOUT   = DEF_RDY_TIMEOUT,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int RELEASE_DELAY = DEF_RELEASE_DELAY
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       soft_reset,
  input  logic       idelay_rdy,
  output logic       idelay_rst,
  output logic       app_rst,
  output logic       init_done,
  output logic       init_fail,
  output logic [1:0] retry_count,
  output logic       rdy_lost
);

  localparam int RW  = cnt_w(RST_CYCLES);
  localparam int TW  = cnt_w(RDY_TIMEOUT);
  localparam int SW  = cnt_w(RELEASE_DELAY);
  localparam int RTW = cnt_w(MAX_RETRIES);

  localparam logic [RW-1:0]  RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(RDY_TIMEOUT);
  localparam logic [SW-1:0]  SET_LAST = SW'(RELEASE_DELAY);
  localparam logic [RTW-1:0] RTY_MAX  = RTW'(MAX_RETRIES);

  seq_state_t     r_state, w_state;
  logic [RW-1:0]  r_rst_cnt, w_rst_cnt;
  logic [TW-1:0]  r_to_cnt, w_to_cnt;
  logic [SW-1:0]  r_set_cnt, w_set_cnt;
  logic [RTW-1:0] r_retry, w_retry;
  logic           r_low, w_low;
  logic           r_idelay_rst, w_idelay_rst;
  logic           r_app_rst, w_app_rst;
  logic           r_init_done, w_init_done;
  logic           r_init_fail, w_init_fail;
  logic           r_rdy_lost, w_rdy_lost;
  logic           w_rdy_s;

  bit_synchroniser #(
    .STAGES(2)
  ) u_rdy_sync (
    .i_clk(sys_clk),
    .i_rst(sys_rst),
    .i_d  (idelay_rdy),
    .o_q  (w_rdy_s)
  );

  // State, counters and all outputs are registered together
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= ASSERT_RST;
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
      r_set_cnt    <= '0;
      r_retry      <= '0;
      r_low        <= 1'b0;
      r_idelay_rst <= 1'b1;
      r_app_rst    <= 1'b1;
      r_init_done  <= 1'b0;
      r_init_fail  <= 1'b0;
      r_rdy_lost   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_rst_cnt    <= w_rst_cnt;
      r_to_cnt     <= w_to_cnt;
      r_set_cnt    <= w_set_cnt;
      r_retry      <= w_retry;
      r_low        <= w_low;
      r_idelay_rst <= w_idelay_rst;
      r_app_rst    <= w_app_rst;
      r_init_done  <= w_init_done;
      r_init_fail  <= w_init_fail;
      r_rdy_lost   <= w_rdy_lost;
    end
  end

  // Next state, counters and next output values; soft_reset overrides all
  always_comb begin
    w_state      = r_state;
    w_rst_cnt    = r_rst_cnt;
    w_to_cnt     = r_to_cnt;
    w_set_cnt    = r_set_cnt;
    w_retry      = r_retry;
    w_low        = r_low;
    w_idelay_rst = r_idelay_rst;
    w_app_rst    = r_app_rst;
    w_init_done  = r_init_done;
    w_init_fail  = r_init_fail;
    w_rdy_lost   = r_rdy_lost;

    if (soft_reset) begin
      w_state      = ASSERT_RST;
      w_rst_cnt    = '0;
      w_retry      = '0;
      w_low        = 1'b0;
      w_idelay_rst = 1'b1;
      w_app_rst    = 1'b1;
      w_init_done  = 1'b0;
      w_init_fail  = 1'b0;
      w_rdy_lost   = 1'b0;
    end else begin
      unique case (r_state)
        ASSERT_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            w_state      = WAIT_RDY;
            w_idelay_rst = 1'b0;
            w_to_cnt     = '0;
          end else begin
            w_rst_cnt = r_rst_cnt + RW'(1);
          end
        end
        WAIT_RDY: begin
          // Ready beats a coincident timeout
          if (w_rdy_s) begin
            w_state   = SETTLE;
            w_set_cnt = '0;
          end else if (r_to_cnt == TO_LAST) begin
            if (r_retry < RTY_MAX) begin
              w_retry      = r_retry + RTW'(1);
              w_state      = ASSERT_RST;
              w_rst_cnt    = '0;
              w_idelay_rst = 1'b1;
            end else begin
              w_state     = FAIL;
              w_init_fail = 1'b1;
            end
          end else begin
            w_to_cnt = r_to_cnt + TW'(1);
          end
        end
        SETTLE: begin
          // A dropout restarts the wait without costing a retry
          if (!w_rdy_s) begin
            w_state  = WAIT_RDY;
            w_to_cnt = '0;
          end else if (r_set_cnt == SET_LAST) begin
            w_state     = RUN;
            w_app_rst   = 1'b0;
            w_init_done = 1'b1;
            w_low       = 1'b0;
          end else begin
            w_set_cnt = r_set_cnt + SW'(1);
          end
        end
        RUN: begin
          // Two consecutive low samples mean ready was really lost
          if (!w_rdy_s) begin
            if (r_low) begin
              w_state      = ASSERT_RST;
              w_rst_cnt    = '0;
              w_idelay_rst = 1'b1;
              w_app_rst    = 1'b1;
              w_init_done  = 1'b0;
              w_retry      = '0;
              w_rdy_lost   = 1'b1;
              w_low        = 1'b0;
            end else begin
              w_low = 1'b1;
            end
          end else begin
            w_low = 1'b0;
          end
        end
        FAIL: begin
          w_idelay_rst = 1'b0;
          w_app_rst    = 1'b1;
          w_init_fail  = 1'b1;
        end
        default: begin
          w_state      = ASSERT_RST;
          w_rst_cnt    = '0;
          w_idelay_rst = 1'b1;
          w_app_rst    = 1'b1;
          w_init_done  = 1'b0;
        end
      endcase
    end
  end

  assign idelay_rst  = r_idelay_rst;
  assign app_rst     = r_app_rst;
  assign init_done   = r_init_done;
  assign init_fail   = r_init_fail;
  assign retry_count = 2'(r_retry);
  assign rdy_lost    = r_rdy_lost;

endmodule

// File: tb/tb_idelay_reset_sequencer.sv
// Directed bench for idelay_reset_sequencer.
// dut_a: default timing; dut_b: RDY_TIMEOUT=63 for retry/fail paths.
module tb_idelay_reset_sequencer;

  // Exact figures for this implementation (edges counted after sys_rst
  // release or after the edge that samples soft_reset/loss of ready):
  //   idelay_rst falls on edge 20; app_rst falls on edge 38 when rdy is
  //   already high (20 + 1 + 2 + 16 - 1: the synchroniser fills during
  //   ASSERT_RST, SETTLE needs 17 edges to see the count complete).
  //   From a rdy rise while in WAIT_RDY, app_rst falls on edge 20.
  //   dut_b: each attempt is 20 + 64 edges, FAIL reached on edge 336.

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic soft_reset = 1'b0;
  logic idelay_rdy = 1'b0;

  logic       a_idelay_rst, a_app_rst, a_init_done, a_init_fail, a_rdy_lost;
  logic [1:0] a_retry;
  logic       b_idelay_rst, b_app_rst, b_init_done, b_init_fail, b_rdy_lost;
  logic [1:0] b_retry;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  idelay_reset_sequencer dut_a (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .soft_reset (soft_reset),
    .idelay_rdy (idelay_rdy),
    .idelay_rst (a_idelay_rst),
    .app_rst    (a_app_rst),
    .init_done  (a_init_done),
    .init_fail  (a_init_fail),
    .retry_count(a_retry),
    .rdy_lost   (a_rdy_lost)
  );

  idelay_reset_sequencer #(
    .RDY_TIMEOUT(63)
  ) dut_b (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .soft_reset (soft_reset),
    .idelay_rdy (idelay_rdy),
    .idelay_rst (b_idelay_rst),
    .app_rst    (b_app_rst),
    .init_done  (b_init_done),
    .init_fail  (b_init_fail),
    .retry_count(b_retry),
    .rdy_lost   (b_rdy_lost)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    sys_rst    = 1'b1;
    soft_reset = 1'b0;
    idelay_rdy = rdy;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  // Edge index of first idelay_rst low and first app_rst low on dut_a
  task automatic measure_a(output int k_id, output int k_app, input int limit);
    k_id  = -1;
    k_app = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (k_id < 0 && a_idelay_rst === 1'b0) k_id = k;
      if (a_app_rst === 1'b0) begin
        k_app = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int kid, kapp;
    sys_rst    = 1'b1;
    idelay_rdy = 1'b1;
    step();
    step();
    n_tests++; if (a_idelay_rst !== 1'b1) begin n_fail++; $display("FAIL rst_idelay_rst got=%b exp=1", a_idelay_rst); end
    n_tests++; if (a_app_rst !== 1'b1) begin n_fail++; $display("FAIL rst_app_rst got=%b exp=1", a_app_rst); end
    n_tests++; if (a_init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done got=%b exp=0", a_init_done); end
    n_tests++; if (a_init_fail !== 1'b0) begin n_fail++; $display("FAIL rst_init_fail got=%b exp=0", a_init_fail); end
    n_tests++; if (a_retry !== 2'd0) begin n_fail++; $display("FAIL rst_retry got=%0d exp=0", a_retry); end
    n_tests++; if (a_rdy_lost !== 1'b0) begin n_fail++; $display("FAIL rst_rdy_lost got=%b exp=0", a_rdy_lost); end
    sys_rst = 1'b0;
    measure_a(kid, kapp, 80);
    n_tests++; if (kid !== 20) begin n_fail++; $display("FAIL t1_idelay_fall got=%0d exp=20", kid); end
    n_tests++; if (kapp !== 38) begin n_fail++; $display("FAIL t1_app_fall got=%0d exp=38", kapp); end
    n_tests++; if (a_init_done !== 1'b1) begin n_fail++; $display("FAIL t1_init_done got=%b exp=1", a_init_done); end
  endtask

  task automatic test_late_rdy();
    int kapp;
    do_reset(1'b0);
    repeat (20) step();
    n_tests++; if (a_idelay_rst !== 1'b0) begin n_fail++; $display("FAIL t2_idelay_fall got=%b exp=0", a_idelay_rst); end
    repeat (100) step();
    n_tests++; if (a_app_rst !== 1'b1) begin n_fail++; $display("FAIL t2_wait_app got=%b exp=1", a_app_rst); end
    n_tests++; if (a_idelay_rst !== 1'b0) begin n_fail++; $display("FAIL t2_wait_no_pulse got=%b exp=0", a_idelay_rst); end
    n_tests++; if (a_retry !== 2'd0) begin n_fail++; $display("FAIL t2_retry got=%0d exp=0", a_retry); end
    idelay_rdy = 1'b1;
    kapp = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (a_app_rst === 1'b0) begin
        kapp = k;
        break;
      end
    end
    n_tests++; if (kapp !== 20) begin n_fail++; $display("FAIL t2_app_fall got=%0d exp=20", kapp); end
    n_tests++; if (a_init_done !== 1'b1) begin n_fail++; $display("FAIL t2_init_done got=%b exp=1", a_init_done); end
  endtask

  task automatic test_timeout();
    int pulses, kfail, r84;
    logic prev;
    do_reset(1'b0);
    prev   = 1'b1;
    pulses = 1;
    kfail  = -1;
    r84    = -1;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (b_idelay_rst === 1'b1 && prev === 1'b0) pulses++;
      prev = b_idelay_rst;
      if (k == 84) r84 = int'(b_retry);
      if (kfail < 0 && b_init_fail === 1'b1) kfail = k;
    end
    n_tests++; if (r84 !== 1) begin n_fail++; $display("FAIL t3_retry_first got=%0d exp=1", r84); end
    n_tests++; if (pulses !== 4) begin n_fail++; $display("FAIL t3_pulses got=%0d exp=4", pulses); end
    n_tests++; if (kfail !== 336) begin n_fail++; $display("FAIL t3_fail_edge got=%0d exp=336", kfail); end
    n_tests++; if (b_retry !== 2'd3) begin n_fail++; $display("FAIL t3_retry got=%0d exp=3", b_retry); end
    n_tests++; if (b_app_rst !== 1'b1) begin n_fail++; $display("FAIL t3_app_rst got=%b exp=1", b_app_rst); end
    n_tests++; if (b_idelay_rst !== 1'b0) begin n_fail++; $display("FAIL t3_idelay_rst got=%b exp=0", b_idelay_rst); end
    n_tests++; if (b_init_done !== 1'b0) begin n_fail++; $display("FAIL t3_init_done got=%b exp=0", b_init_done); end
  endtask

  task automatic test_rdy_lost();
    int kid, kapp;
    do_reset(1'b1);
    measure_a(kid, kapp, 80);
    n_tests++; if (kapp !== 38) begin n_fail++; $display("FAIL t4_start_app got=%0d exp=38", kapp); end
    idelay_rdy = 1'b0;
    step();
    idelay_rdy = 1'b1;
    repeat (6) step();
    n_tests++; if (a_app_rst !== 1'b0) begin n_fail++; $display("FAIL t4_glitch_app got=%b exp=0", a_app_rst); end
    n_tests++; if (a_rdy_lost !== 1'b0) begin n_fail++; $display("FAIL t4_glitch_lost got=%b exp=0", a_rdy_lost); end
    idelay_rdy = 1'b0;
    repeat (3) step();
    idelay_rdy = 1'b1;
    step();
    n_tests++; if (a_rdy_lost !== 1'b1) begin n_fail++; $display("FAIL t4_lost got=%b exp=1", a_rdy_lost); end
    n_tests++; if (a_app_rst !== 1'b1) begin n_fail++; $display("FAIL t4_lost_app got=%b exp=1", a_app_rst); end
    n_tests++; if (a_init_done !== 1'b0) begin n_fail++; $display("FAIL t4_lost_done got=%b exp=0", a_init_done); end
    n_tests++; if (a_idelay_rst !== 1'b1) begin n_fail++; $display("FAIL t4_lost_pulse got=%b exp=1", a_idelay_rst); end
    measure_a(kid, kapp, 80);
    n_tests++; if (kid !== 20) begin n_fail++; $display("FAIL t4_rec_idelay got=%0d exp=20", kid); end
    n_tests++; if (kapp !== 38) begin n_fail++; $display("FAIL t4_rec_app got=%0d exp=38", kapp); end
    n_tests++; if (a_rdy_lost !== 1'b1) begin n_fail++; $display("FAIL t4_sticky got=%b exp=1", a_rdy_lost); end
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    n_tests++; if (a_rdy_lost !== 1'b0) begin n_fail++; $display("FAIL t4_soft_clr got=%b exp=0", a_rdy_lost); end
    n_tests++; if (a_app_rst !== 1'b1) begin n_fail++; $display("FAIL t4_soft_app got=%b exp=1", a_app_rst); end
    n_tests++; if (a_init_done !== 1'b0) begin n_fail++; $display("FAIL t4_soft_done got=%b exp=0", a_init_done); end
  endtask

  task automatic test_soft_reset();
    int kid, kapp;
    do_reset(1'b0);
    repeat (336) step();
    n_tests++; if (b_init_fail !== 1'b1) begin n_fail++; $display("FAIL t5_in_fail got=%b exp=1", b_init_fail); end
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    idelay_rdy = 1'b1;
    n_tests++; if (b_init_fail !== 1'b0) begin n_fail++; $display("FAIL t5_fail_clr got=%b exp=0", b_init_fail); end
    n_tests++; if (b_retry !== 2'd0) begin n_fail++; $display("FAIL t5_retry_clr got=%0d exp=0", b_retry); end
    n_tests++; if (b_idelay_rst !== 1'b1) begin n_fail++; $display("FAIL t5_pulse got=%b exp=1", b_idelay_rst); end
    n_tests++; if (b_app_rst !== 1'b1) begin n_fail++; $display("FAIL t5_app got=%b exp=1", b_app_rst); end
    kid = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (b_idelay_rst === 1'b0) begin
        kid = k;
        break;
      end
    end
    n_tests++; if (kid !== 20) begin n_fail++; $display("FAIL t5_pulse_len got=%0d exp=20", kid); end
    repeat (5) step();
    n_tests++; if (a_app_rst !== 1'b1) begin n_fail++; $display("FAIL t5_settle_app got=%b exp=1", a_app_rst); end
    n_tests++; if (a_idelay_rst !== 1'b0) begin n_fail++; $display("FAIL t5_settle_idl got=%b exp=0", a_idelay_rst); end
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    n_tests++; if (a_idelay_rst !== 1'b1) begin n_fail++; $display("FAIL t5_settle_pulse got=%b exp=1", a_idelay_rst); end
    measure_a(kid, kapp, 80);
    n_tests++; if (kid !== 20) begin n_fail++; $display("FAIL t5_settle_idelay got=%0d exp=20", kid); end
    n_tests++; if (kapp !== 38) begin n_fail++; $display("FAIL t5_settle_rel got=%0d exp=38", kapp); end
  endtask

  task automatic test_settle_drop();
    int kapp;
    do_reset(1'b0);
    repeat (84) step();
    n_tests++; if (b_retry !== 2'd1) begin n_fail++; $display("FAIL t5b_retry got=%0d exp=1", b_retry); end
    idelay_rdy = 1'b1;
    repeat (26) step();
    idelay_rdy = 1'b0;
    repeat (4) step();
    n_tests++; if (b_app_rst !== 1'b1) begin n_fail++; $display("FAIL t5b_app got=%b exp=1", b_app_rst); end
    n_tests++; if (b_idelay_rst !== 1'b0) begin n_fail++; $display("FAIL t5b_no_pulse got=%b exp=0", b_idelay_rst); end
    n_tests++; if (b_retry !== 2'd1) begin n_fail++; $display("FAIL t5b_retry_kept got=%0d exp=1", b_retry); end
    idelay_rdy = 1'b1;
    kapp = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (b_app_rst === 1'b0) begin
        kapp = k;
        break;
      end
    end
    n_tests++; if (kapp !== 20) begin n_fail++; $display("FAIL t5b_app_fall got=%0d exp=20", kapp); end
    n_tests++; if (b_retry !== 2'd1) begin n_fail++; $display("FAIL t5b_retry_run got=%0d exp=1", b_retry); end
  endtask

  task automatic test_async_reset();
    int kid, kapp;
    do_reset(1'b0);
    repeat (30) step();
    n_tests++; if (a_idelay_rst !== 1'b0) begin n_fail++; $display("FAIL t6_wait_idl got=%b exp=0", a_idelay_rst); end
    #2;
    sys_rst = 1'b1;
    #1;
    n_tests++; if (a_idelay_rst !== 1'b1) begin n_fail++; $display("FAIL t6_async_idl got=%b exp=1", a_idelay_rst); end
    n_tests++; if (a_app_rst !== 1'b1) begin n_fail++; $display("FAIL t6_async_app got=%b exp=1", a_app_rst); end
    idelay_rdy = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    measure_a(kid, kapp, 80);
    n_tests++; if (kid !== 20) begin n_fail++; $display("FAIL t6_idelay_fall got=%0d exp=20", kid); end
    n_tests++; if (kapp !== 38) begin n_fail++; $display("FAIL t6_app_fall got=%0d exp=38", kapp); end
  endtask

  initial begin
    test_reset();
    test_late_rdy();
    test_timeout();
    test_rdy_lost();
    test_soft_reset();
    test_settle_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
